a2d_round_sched: RTL

- Round scheduler for the shared A2D SPI master (SPI_mnrch) on the ADC128S.
- Each `nxt` request starts one full round that converts the left load cell, right load cell, steer pot and battery.
- The round uses the ADC's one-frame-delayed response: each frame carries the next channel command while returning the previous channel's result, so a round is 5 frames.
- All four results are buffered in shadow registers and published atomically, so the balance, steer-enable and battery-check logic never sees a mixed round.

---
 rtl/a2d_round_sched_pkg.sv | 44 ++++
 rtl/a2d_round_sched_tmr.sv | 29 ++
 rtl/a2d_round_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/a2d_round_sched_pkg.sv
// Shared constants, types and command helpers for the A2D round scheduler.
package a2d_pkg;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned NUM_FRAMES = 5;
  localparam int unsigned RES_W      = 12;
  localparam int unsigned CMD_W      = 16;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  localparam logic [2:0] CH_ORDER [NUM_CH] = '{CH_LFT, CH_RGHT, CH_STEER, CH_BATT};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_WAIT,
    ST_GAP,
    ST_PUB,
    ST_ABORT
  } state_t;

  typedef logic [RES_W-1:0] result_t;

  typedef struct packed {
    result_t lft;
    result_t rght;
    result_t steer;
    result_t batt;
  } round_t;

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

  // The trailing frame only exists to clock out the last result; it re-addresses channel 0.
  function automatic logic [CMD_W-1:0] frame_cmd(input logic [2:0] k);
    if (k < 3'(NUM_CH)) return mk_cmd(CH_ORDER[k[1:0]]);
    return mk_cmd(CH_LFT);
  endfunction

endpackage

// File: rtl/a2d_round_sched_tmr.sv
// Loadable down-counter; expired is high while the count sits at zero.
module sched_tmr #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Load has priority; the counter parks at zero until reloaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b1;
    end else if (load) begin
      cnt     <= value;
      expired <= (value == '0);
    end else if (tick && !expired) begin
      cnt     <= cnt - W'(1);
      expired <= (cnt == W'(1));
    end
  end

endmodule

// File: rtl/a2d_round_sched.sv
// Sequences five SPI frames per round over the ADC's pipelined response and
// publishes the four channel results together.
module a2d_round_sched
  import a2d_pkg::*;
#(
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        clr_err,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] ld_cell_lft,
  output logic [11:0] ld_cell_rght,
  output logic [11:0] steerPot,
  output logic [11:0] batt,
  output logic        vld,
  output logic        busy,
  output logic        err,
  output logic        ovr
);

  localparam int unsigned TMR_W = $clog2(TMO_CYC + GAP_CYC + 1);
  // WAIT is entered one cycle after wrt and the expiry is seen one cycle late.
  localparam logic [TMR_W-1:0] TMO_LD     = TMR_W'(TMO_CYC - 2);
  localparam logic [TMR_W-1:0] GAP_LD     = TMR_W'(GAP_CYC - 1);
  localparam logic [2:0]       LAST_FRAME = 3'(NUM_FRAMES - 1);

  state_t           state;
  logic [2:0]       k;
  logic [1:0]       sidx;
  logic             pending;
  result_t          shadow [NUM_CH];
  round_t           pub;
  logic             tmr_load;
  logic             tmr_tick;
  logic             tmr_expired;
  logic [TMR_W-1:0] tmr_value;
  logic             unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:12];

  // Frame k returns the result requested by frame k-1 (wraps to 3 for k=4).
  assign sidx = k[1:0] - 2'd1;

  assign ld_cell_lft  = pub.lft;
  assign ld_cell_rght = pub.rght;
  assign steerPot     = pub.steer;
  assign batt         = pub.batt;

  always_comb begin
    tmr_load  = 1'b0;
    tmr_tick  = 1'b0;
    tmr_value = GAP_LD;
    case (state)
      ST_XFER: begin
        tmr_load  = 1'b1;
        tmr_value = TMO_LD;
      end
      ST_WAIT: begin
        tmr_tick = 1'b1;
        tmr_load = done && (k != LAST_FRAME);
      end
      ST_GAP:  tmr_tick = 1'b1;
      default: ;
    endcase
  end

  sched_tmr #(
    .W(TMR_W)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (tmr_value),
    .tick   (tmr_tick),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      k       <= '0;
      pending <= 1'b0;
      wrt     <= 1'b0;
      vld     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      ovr     <= 1'b0;
      cmd     <= '0;
      pub     <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (nxt || pending) begin
            state <= ST_XFER;
            wrt   <= 1'b1;
            cmd   <= frame_cmd(3'd0);
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        ST_XFER: state <= ST_WAIT;
        ST_WAIT: begin
          if (done) begin
            if (k != 3'd0) shadow[sidx] <= rd_data[11:0];
            if (k == LAST_FRAME) begin
              pub   <= {shadow[0], shadow[1], shadow[2], rd_data[11:0]};
              vld   <= 1'b1;
              busy  <= 1'b0;
              k     <= '0;
              state <= ST_PUB;
            end else begin
              state <= ST_GAP;
            end
          end else if (tmr_expired) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            k     <= '0;
            state <= ST_ABORT;
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
          end
        end
        ST_GAP: begin
          if (tmr_expired) begin
            state <= ST_XFER;
            wrt   <= 1'b1;
            k     <= k + 3'd1;
            cmd   <= frame_cmd(k + 3'd1);
          end
        end
        ST_PUB, ST_ABORT: state <= ST_IDLE;
        default:          state <= ST_IDLE;
      endcase

      // One request may queue behind the active round; a second one is dropped.
      if (state == ST_IDLE) begin
        pending <= 1'b0;
        if (nxt && pending) ovr <= 1'b1;
      end else if (nxt) begin
        if (pending) ovr <= 1'b1;
        else         pending <= 1'b1;
      end

      if (clr_err) begin
        err <= 1'b0;
        ovr <= 1'b0;
      end
    end
  end

endmodule
